// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the video/font RAM arbiter.
package mem_pkg;

    localparam int         ADDR_WIDTH = 16;
    localparam int         DATA_WIDTH = 16;
    localparam logic [3:0] VGA_BASE   = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port video/font RAM: VGA fetches win via a
// one-cycle reservation, CPU single-word accesses fill the free cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = mem_pkg::ADDR_WIDTH,
    parameter int VGA_ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-VGA_ADDR_WIDTH-1:0] VGA_BASE = mem_pkg::VGA_BASE
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_vga_access,
    input  logic                            i_vga_cs,
    input  logic [VGA_ADDR_WIDTH-1:0]       i_vga_addr,
    output logic [mem_pkg::DATA_WIDTH-1:0]  o_vga_dat,
    input  logic                            i_cpu_cs,
    input  logic                            i_cpu_we,
    input  logic [ADDR_WIDTH-1:0]           i_cpu_addr,
    input  logic [mem_pkg::DATA_WIDTH-1:0]  i_cpu_dat,
    output logic [mem_pkg::DATA_WIDTH-1:0]  o_cpu_dat,
    output logic                            o_cpu_ack,
    output logic                            o_ram_cs,
    output logic                            o_ram_we,
    output logic [ADDR_WIDTH-1:0]           o_ram_addr,
    output logic [mem_pkg::DATA_WIDTH-1:0]  o_ram_dat,
    input  logic [mem_pkg::DATA_WIDTH-1:0]  i_ram_dat,
    output logic                            o_err
);

    import mem_pkg::*;

    state_e                  state_q, state_d;
    logic                    resv_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   cpu_dat_q, cpu_dat_d;
    logic                    vga_err;

    // A VGA read is only legal in a reserved cycle; ISSUE is never reserved.
    assign vga_err = i_vga_cs && (!resv_q || (state_q == ST_ISSUE));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            resv_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            resv_q    <= i_vga_access;
            err_q     <= err_q | vga_err;
            cpu_dat_q <= cpu_dat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_dat_d = cpu_dat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cpu_cs && !resv_q && !i_vga_access && !i_vga_cs)
                    state_d = ST_ISSUE;
            end
            // A VGA read stole the issue cycle: drop back and retry without ack.
            ST_ISSUE: state_d = vga_err ? ST_IDLE : ST_RESP;
            ST_RESP: begin
                state_d = ST_ACK;
                if (!i_cpu_we)
                    cpu_dat_d = i_ram_dat;
            end
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ram_cs   = 1'b0;
        o_ram_we   = 1'b0;
        o_ram_addr = '0;
        o_ram_dat  = '0;
        if (i_vga_cs) begin
            o_ram_cs   = 1'b1;
            o_ram_addr = {VGA_BASE, i_vga_addr};
        end else if (state_q == ST_ISSUE) begin
            o_ram_cs   = 1'b1;
            o_ram_we   = i_cpu_we;
            o_ram_addr = i_cpu_addr;
            o_ram_dat  = i_cpu_dat;
        end
    end

    assign o_vga_dat = i_ram_dat;
    assign o_cpu_dat = cpu_dat_q;
    assign o_cpu_ack = (state_q == ST_ACK);
    assign o_err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle synchronous RAM behind it.
module sync_ram_model #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (cs) begin
            if (we) mem[addr] <= wdat;
            rdat <= mem[addr];
        end
    end
endmodule

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_access, vga_cs;
    logic [11:0] vga_addr;
    logic [15:0] vga_dat;
    logic        cpu_cs, cpu_we;
    logic [15:0] cpu_addr, cpu_wdat, cpu_rdat;
    logic        cpu_ack;
    logic        ram_cs, ram_we;
    logic [15:0] ram_addr, ram_wdat, ram_rdat;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        scan_done;
    logic        vprev;
    int          lat;
    logic [15:0] rd;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH(16), .VGA_ADDR_WIDTH(12), .VGA_BASE(4'h0)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_vga_access(vga_access), .i_vga_cs(vga_cs), .i_vga_addr(vga_addr),
        .o_vga_dat(vga_dat),
        .i_cpu_cs(cpu_cs), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_dat(cpu_wdat), .o_cpu_dat(cpu_rdat), .o_cpu_ack(cpu_ack),
        .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_dat(ram_wdat), .i_ram_dat(ram_rdat), .o_err(err)
    );

    sync_ram_model #(.AW(16), .DW(16)) u_ram (
        .clk(clk), .cs(ram_cs), .we(ram_we), .addr(ram_addr),
        .wdat(ram_wdat), .rdat(ram_rdat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single CPU access; lat counts cycles from the cs cycle to the ack cycle.
    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output int l, output logic [15:0] r);
        cpu_cs   = 1'b1;
        cpu_we   = we;
        cpu_addr = a;
        cpu_wdat = d;
        l = 0;
        @(negedge clk);
        while (!cpu_ack && l < 30) begin
            @(negedge clk);
            l++;
        end
        check("cpu_ack_seen", 32'(cpu_ack), 32'd1);
        r = cpu_rdat;
        step();
        cpu_cs = 1'b0;
    endtask

    // While a VGA read is on the bus the RAM must carry exactly the VGA address.
    always @(negedge clk) begin
        if (mon_en && vga_cs) begin
            check("mon_vga_addr", 32'(ram_addr), 32'({4'h0, vga_addr}));
            check("mon_vga_we", 32'(ram_we), 32'd0);
        end
    end

    initial begin
        rst = 1'b1; vga_access = 1'b0; vga_cs = 1'b0; vga_addr = '0;
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdat = '0;
        scan_done = 1'b0; vprev = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_dat", 32'(ram_wdat), 32'd0);
        check("rst_cpu_dat", 32'(cpu_rdat), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Uncontended write then read
        cpu_op(1'b1, 16'h1234, 16'hBEEF, lat, rd);
        check("wr_lat", 32'(lat), 32'd3);
        check("wr_cpu_dat_kept", 32'(rd), 32'd0);
        step();
        cpu_op(1'b0, 16'h1234, 16'h0000, lat, rd);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_data", 32'(rd), 32'hBEEF);
        step();

        // VGA reservation then read of 0x800
        cpu_op(1'b1, 16'h0800, 16'h4142, lat, rd);
        step();
        vga_access = 1'b1;
        step();
        vga_access = 1'b0; vga_cs = 1'b1; vga_addr = 12'h800;
        @(negedge clk);
        check("vga_ram_addr", 32'(ram_addr), 32'h0800);
        check("vga_ram_cs", 32'(ram_cs), 32'd1);
        check("vga_ram_we", 32'(ram_we), 32'd0);
        step();
        vga_cs = 1'b0;
        @(negedge clk);
        check("vga_dat", 32'(vga_dat), 32'h4142);
        check("vga_err", 32'(err), 32'd0);
        step();

        // CPU request in the same cycle as vga_access: CPU must wait
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0800; vga_access = 1'b1;
        @(negedge clk);
        check("ct_t0_ram_cs", 32'(ram_cs), 32'd0);
        step();
        vga_access = 1'b0; vga_cs = 1'b1; vga_addr = 12'h800;
        @(negedge clk);
        check("ct_t1_ram_addr", 32'(ram_addr), 32'h0800);
        check("ct_t1_ram_we", 32'(ram_we), 32'd0);
        step();
        vga_cs = 1'b0;
        @(negedge clk);
        check("ct_t2_ram_cs", 32'(ram_cs), 32'd0);
        step();
        @(negedge clk);
        check("ct_t3_issue_cs", 32'(ram_cs), 32'd1);
        check("ct_t3_issue_addr", 32'(ram_addr), 32'h0800);
        step();
        @(negedge clk);
        check("ct_t4_ack", 32'(cpu_ack), 32'd0);
        step();
        @(negedge clk);
        check("ct_t5_ack", 32'(cpu_ack), 32'd1);
        check("ct_t5_data", 32'(cpu_rdat), 32'h4142);
        check("ct_err", 32'(err), 32'd0);
        step();
        cpu_cs = 1'b0;
        repeat (2) step();

        // Scanline: VGA access at x%8==3,5; CPU reads with one idle cycle between
        mon_en = 1'b1;
        fork
            begin
                for (int x = 0; x < 800; x++) begin
                    vga_access = ((x % 8) == 3) || ((x % 8) == 5);
                    vga_cs     = vprev;
                    vga_addr   = 12'(x);
                    vprev      = vga_access;
                    step();
                end
                vga_access = 1'b0;
                vga_cs     = vprev;
                step();
                vga_cs    = 1'b0;
                scan_done = 1'b1;
            end
            begin
                int n = 0;
                int sl;
                logic [15:0] sr;
                while (!scan_done) begin
                    if (n % 2 == 0) begin
                        cpu_op(1'b0, 16'h1234, 16'h0000, sl, sr);
                        check("scan_rd_1234", 32'(sr), 32'hBEEF);
                    end else begin
                        cpu_op(1'b0, 16'h0800, 16'h0000, sl, sr);
                        check("scan_rd_0800", 32'(sr), 32'h4142);
                    end
                    check("scan_lat_le6", 32'(sl <= 6), 32'd1);
                    step();
                    n++;
                end
            end
        join
        mon_en = 1'b0;
        check("scan_err", 32'(err), 32'd0);
        repeat (3) step();

        // VGA read without a reservation: sticky error, read still served
        vga_cs = 1'b1; vga_addr = 12'h800;
        @(negedge clk);
        check("perr_pre", 32'(err), 32'd0);
        check("perr_ram_addr", 32'(ram_addr), 32'h0800);
        step();
        vga_cs = 1'b0;
        @(negedge clk);
        check("perr_set", 32'(err), 32'd1);
        check("perr_vga_dat", 32'(vga_dat), 32'h4142);
        repeat (3) step();
        @(negedge clk);
        check("perr_sticky", 32'(err), 32'd1);
        step();

        // Reset during RESP of a CPU write
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdat = 16'h5A5A;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mr_resp_ack", 32'(cpu_ack), 32'd0);
        step();
        rst = 1'b0; cpu_cs = 1'b0;
        @(negedge clk);
        check("mr_no_ack", 32'(cpu_ack), 32'd0);
        check("mr_err_clr", 32'(err), 32'd0);
        step();
        @(negedge clk);
        check("mr_no_ack2", 32'(cpu_ack), 32'd0);
        step();
        cpu_op(1'b0, 16'h0100, 16'h0000, lat, rd);
        check("mr_idle_lat", 32'(lat), 32'd3);
        check("mr_written", 32'(rd), 32'h5A5A);
        check("mr_err_end", 32'(err), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
